// File: rtl/stripe_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : stripe_n_if
//  Description : Bus bundle for the stripe_n lane striper.
//                master drives the word stream and group controls,
//                slave (the striper) drives lane data, lane valids and busy.
//  Signals     : dataIn/validIn  - input word and its qualifier
//                lane_cnt        - requested active lane count
//                align_mode      - 0 immediate, 1 aligned groups
//                flush           - close a partial aligned group
//                laneOut         - LANES packed lanes of DATA_WIDTH bits
//                validOut        - per-lane valid
//                busy            - group partially filled
//  Revision    : 1.0 - initial release
// ============================================================================
interface stripe_n_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
);
    logic [DATA_WIDTH-1:0]       dataIn;
    logic                        validIn;
    logic [3:0]                  lane_cnt;
    logic                        align_mode;
    logic                        flush;
    logic [LANES*DATA_WIDTH-1:0] laneOut;
    logic [LANES-1:0]            validOut;
    logic                        busy;

    modport master (
        output dataIn, validIn, lane_cnt, align_mode, flush,
        input  laneOut, validOut, busy
    );

    modport slave (
        input  dataIn, validIn, lane_cnt, align_mode, flush,
        output laneOut, validOut, busy
    );
endinterface
`default_nettype wire

// File: rtl/stripe_n.sv
`default_nettype none
// ============================================================================
//  Module      : stripe_n
//  Description : Distributes a word stream across up to LANES output lanes.
//                Immediate mode writes each word straight to its lane;
//                aligned mode buffers a whole group and emits it in one
//                cycle, with flush padding a partial group with PAD_WORD.
//  Ports       : clk_2f - clock, all state on rising edge
//                reset  - asynchronous, active-low
//                bus    - stripe_n_if slave modport (data, controls, lanes)
//  Revision    : 1.0 - initial release
// ============================================================================
module stripe_n #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LANES      = 4,
    parameter logic [DATA_WIDTH-1:0] PAD_WORD   = '0
) (
    input  wire logic clk_2f,
    input  wire logic reset,
    stripe_n_if.slave bus
);
    localparam int         PTR_W   = $clog2(LANES);
    localparam logic [3:0] C_LANES = 4'(LANES);

    logic [PTR_W-1:0]      r_ptr;
    logic [3:0]            r_act;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_buf  [LANES];
    logic [DATA_WIDTH-1:0] r_lane [LANES];
    logic [LANES-1:0]      r_valid;

    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [DATA_WIDTH-1:0] w_buf_nxt  [LANES];
    logic [DATA_WIDTH-1:0] w_lane_nxt [LANES];
    logic [LANES-1:0]      w_valid_nxt;
    logic [3:0]            w_act_new;
    logic [3:0]            w_act;
    logic [3:0]            w_ptr_ext;
    logic                  w_mode;
    logic                  w_open;
    logic                  w_last;
    logic                  w_emit;

    always_comb begin
        // A new group may only be configured while no slot is occupied. The
        // freshly sampled configuration already governs the word arriving on
        // that same edge, so slot 0 uses the new lane count and mode.
        w_open = (r_ptr == '0);
        if (bus.lane_cnt == 4'd0 || bus.lane_cnt > C_LANES) begin
            w_act_new = C_LANES;
        end else begin
            w_act_new = bus.lane_cnt;
        end
        w_act     = w_open ? w_act_new : r_act;
        w_mode    = w_open ? bus.align_mode : r_mode;
        w_ptr_ext = 4'(r_ptr);
        w_last    = ((w_ptr_ext + 4'd1) == w_act);
        // Emit when the last slot is written, or when flush closes a
        // non-empty group (a word arriving with flush is accepted first).
        w_emit    = w_mode && ((bus.validIn && w_last) || (bus.flush && !w_open));

        w_ptr_nxt   = r_ptr;
        w_valid_nxt = '0;
        w_lane_nxt  = r_lane;
        w_buf_nxt   = r_buf;

        if (bus.validIn) begin
            w_ptr_nxt = w_last ? '0 : r_ptr + PTR_W'(1);
        end
        if (w_emit) begin
            w_ptr_nxt = '0;
        end

        for (int k = 0; k < LANES; k++) begin
            if (4'(k) < w_act) begin
                if (!w_mode) begin
                    if (bus.validIn && (4'(k) == w_ptr_ext)) begin
                        w_lane_nxt[k]  = bus.dataIn;
                        w_valid_nxt[k] = 1'b1;
                    end
                end else begin
                    if (bus.validIn && (4'(k) == w_ptr_ext)) begin
                        w_buf_nxt[k] = bus.dataIn;
                    end else if (w_emit && (4'(k) >= w_ptr_ext)) begin
                        w_buf_nxt[k] = PAD_WORD;
                    end
                    if (w_emit) begin
                        w_lane_nxt[k]  = w_buf_nxt[k];
                        w_valid_nxt[k] = 1'b1;
                    end
                end
            end else begin
                // Lanes beyond the active count are held at zero.
                w_lane_nxt[k]  = '0;
                w_valid_nxt[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_act   <= C_LANES;
            r_mode  <= 1'b0;
            r_valid <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_buf[k]  <= '0;
                r_lane[k] <= '0;
            end
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_valid <= w_valid_nxt;
            r_buf   <= w_buf_nxt;
            r_lane  <= w_lane_nxt;
            if (w_open) begin
                r_act  <= w_act_new;
                r_mode <= bus.align_mode;
            end
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign bus.laneOut[k*DATA_WIDTH +: DATA_WIDTH] = r_lane[k];
        end
    endgenerate

    assign bus.validOut = r_valid;
    assign bus.busy     = (r_ptr != '0);

endmodule
`default_nettype wire

// File: tb/tb_stripe_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stripe_n
//  Description : Self-checking bench for stripe_n (LANES=4, DATA_WIDTH=32,
//                PAD_WORD=0xDEADBEEF). Expected lane state is queued as each
//                input cycle is driven and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stripe_n;
    localparam int          DW  = 32;
    localparam int          NL  = 4;
    localparam logic [31:0] PAD = 32'hDEAD_BEEF;
    localparam logic [31:0] Z   = 32'h0;

    typedef struct packed {
        logic [3:0]   v;
        logic [127:0] d;
        logic         b;
        logic         cd;
    } exp_t;

    logic clk_2f;
    logic reset;
    int   n_checks;
    int   n_errors;
    exp_t sb [$];

    stripe_n_if #(.DATA_WIDTH(DW), .LANES(NL)) bus ();

    stripe_n #(
        .DATA_WIDTH (DW),
        .LANES      (NL),
        .PAD_WORD   (PAD)
    ) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] L(input logic [31:0] a3, input logic [31:0] a2,
                                       input logic [31:0] a1, input logic [31:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    // One input cycle: drive, queue the expected result, compare after the edge.
    task automatic step(input logic vi, input logic [31:0] di, input logic [3:0] lc,
                        input logic am, input logic fl, input logic [3:0] ev,
                        input logic [127:0] ed, input logic eb, input logic cd);
        exp_t e;
        @(negedge clk_2f);
        bus.validIn    = vi;
        bus.dataIn     = di;
        bus.lane_cnt   = lc;
        bus.align_mode = am;
        bus.flush      = fl;
        sb.push_back('{v: ev, d: ed, b: eb, cd: cd});
        @(posedge clk_2f);
        #1;
        e = sb.pop_front();
        check("validOut", 128'(bus.validOut), 128'(e.v));
        check("busy", 128'(bus.busy), 128'(e.b));
        if (e.cd) check("laneOut", bus.laneOut, e.d);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b0;
        bus.validIn    = 1'b0;
        bus.dataIn     = '0;
        bus.lane_cnt   = 4'd4;
        bus.align_mode = 1'b0;
        bus.flush      = 1'b0;

        #1;
        check("rst_validOut", 128'(bus.validOut), 128'd0);
        check("rst_laneOut", bus.laneOut, 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        repeat (2) @(posedge clk_2f);
        @(negedge clk_2f);
        reset = 1'b1;

        // Immediate mode, 4 lanes, words A0..A7 (A6 preceded by an idle).
        step(1'b1, 32'hA0, 4'd4, 1'b0, 1'b0, 4'b0001, L(Z, Z, Z, 32'hA0), 1'b1, 1'b1);
        step(1'b1, 32'hA1, 4'd4, 1'b0, 1'b0, 4'b0010, L(Z, Z, 32'hA1, 32'hA0), 1'b1, 1'b1);
        step(1'b1, 32'hA2, 4'd4, 1'b0, 1'b0, 4'b0100, L(Z, 32'hA2, 32'hA1, 32'hA0), 1'b1, 1'b1);
        step(1'b1, 32'hA3, 4'd4, 1'b0, 1'b0, 4'b1000, L(32'hA3, 32'hA2, 32'hA1, 32'hA0), 1'b0, 1'b1);
        step(1'b1, 32'hA4, 4'd4, 1'b0, 1'b0, 4'b0001, L(32'hA3, 32'hA2, 32'hA1, 32'hA4), 1'b1, 1'b1);
        step(1'b1, 32'hA5, 4'd4, 1'b0, 1'b0, 4'b0010, L(32'hA3, 32'hA2, 32'hA5, 32'hA4), 1'b1, 1'b1);
        step(1'b0, 32'h77, 4'd4, 1'b0, 1'b1, 4'b0000, L(32'hA3, 32'hA2, 32'hA5, 32'hA4), 1'b1, 1'b1);
        step(1'b1, 32'hA6, 4'd4, 1'b0, 1'b0, 4'b0100, L(32'hA3, 32'hA6, 32'hA5, 32'hA4), 1'b1, 1'b1);
        step(1'b1, 32'hA7, 4'd4, 1'b0, 1'b0, 4'b1000, L(32'hA7, 32'hA6, 32'hA5, 32'hA4), 1'b0, 1'b1);

        // Aligned, 3 lanes: emit one cycle after the third word.
        step(1'b1, 32'h11, 4'd3, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h22, 4'd3, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h33, 4'd3, 1'b1, 1'b0, 4'b0111, L(Z, 32'h33, 32'h22, 32'h11), 1'b0, 1'b1);

        // Aligned, 4 lanes, flush alone after two words.
        step(1'b1, 32'h55, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h66, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b0, 32'h00, 4'd4, 1'b1, 1'b1, 4'b1111, L(PAD, PAD, 32'h66, 32'h55), 1'b0, 1'b1);
        step(1'b0, 32'h00, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b0, 1'b0);

        // Flush together with a word: padded, then a completing word (no pad).
        step(1'b1, 32'h71, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h72, 4'd4, 1'b1, 1'b1, 4'b1111, L(PAD, PAD, 32'h72, 32'h71), 1'b0, 1'b1);
        step(1'b1, 32'h81, 4'd2, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h82, 4'd2, 1'b1, 1'b1, 4'b0011, L(Z, Z, 32'h82, 32'h81), 1'b0, 1'b1);

        // lane_cnt changed mid-group is ignored until the group closes.
        step(1'b1, 32'h91, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h92, 4'd2, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h93, 4'd2, 1'b0, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h94, 4'd2, 1'b1, 1'b0, 4'b1111, L(32'h94, 32'h93, 32'h92, 32'h91), 1'b0, 1'b1);
        step(1'b1, 32'h95, 4'd2, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'h96, 4'd2, 1'b1, 1'b0, 4'b0011, L(Z, Z, 32'h96, 32'h95), 1'b0, 1'b1);

        // Flush with an empty group has no effect.
        step(1'b0, 32'h00, 4'd2, 1'b1, 1'b1, 4'b0000, L(Z, Z, Z, Z), 1'b0, 1'b0);

        // Out-of-range lane_cnt (0, then 9) selects all 4 lanes, immediate mode.
        step(1'b1, 32'hB0, 4'd0, 1'b0, 1'b0, 4'b0001, L(Z, Z, Z, 32'hB0), 1'b1, 1'b0);
        step(1'b1, 32'hB1, 4'd9, 1'b0, 1'b1, 4'b0010, L(Z, Z, 32'hB1, 32'hB0), 1'b1, 1'b0);
        step(1'b1, 32'hB2, 4'd9, 1'b0, 1'b0, 4'b0100, L(Z, 32'hB2, 32'hB1, 32'hB0), 1'b1, 1'b0);
        step(1'b1, 32'hB3, 4'd9, 1'b0, 1'b0, 4'b1000, L(32'hB3, 32'hB2, 32'hB1, 32'hB0), 1'b0, 1'b1);
        step(1'b1, 32'hB4, 4'd9, 1'b0, 1'b0, 4'b0001, L(32'hB3, 32'hB2, 32'hB1, 32'hB4), 1'b1, 1'b1);
        step(1'b1, 32'hB5, 4'd0, 1'b0, 1'b0, 4'b0010, L(32'hB3, 32'hB2, 32'hB5, 32'hB4), 1'b1, 1'b1);
        step(1'b1, 32'hB6, 4'd0, 1'b0, 1'b0, 4'b0100, L(32'hB3, 32'hB6, 32'hB5, 32'hB4), 1'b1, 1'b1);
        step(1'b1, 32'hB7, 4'd0, 1'b0, 1'b0, 4'b1000, L(32'hB7, 32'hB6, 32'hB5, 32'hB4), 1'b0, 1'b1);

        // Reset in the middle of an aligned group (ptr = 2).
        step(1'b1, 32'hC1, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'hC2, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        @(negedge clk_2f);
        bus.validIn = 1'b0;
        reset       = 1'b0;
        #1;
        check("arst_validOut", 128'(bus.validOut), 128'd0);
        check("arst_laneOut", bus.laneOut, 128'd0);
        check("arst_busy", 128'(bus.busy), 128'd0);
        @(negedge clk_2f);
        reset = 1'b1;
        step(1'b1, 32'hC3, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'hC4, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'hC5, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b1, 1'b0);
        step(1'b1, 32'hC6, 4'd4, 1'b1, 1'b0, 4'b1111, L(32'hC6, 32'hC5, 32'hC4, 32'hC3), 1'b0, 1'b1);
        step(1'b0, 32'h00, 4'd4, 1'b1, 1'b0, 4'b0000, L(Z, Z, Z, Z), 1'b0, 1'b0);

        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/stripe_n.md
STRIPE_N -- requirements
Module: stripe_n

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the input word and of each lane.
REQ-002 Parameter LANES, default 4, legal range 2..8: number of physical output lanes.
REQ-003 Parameter PAD_WORD, default 0: word inserted in unused slots on a flush.
REQ-004 clk_2f  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dataIn  input  DATA_WIDTH  input word.
REQ-007 validIn  input  1  dataIn is valid this cycle.
REQ-008 lane_cnt  input  4  requested number of active lanes.
REQ-009 align_mode  input  1  selects the output mode: 0 immediate, 1 aligned.
REQ-010 flush  input  1  in aligned mode, closes a partial group.
REQ-011 laneOut  output  LANES*DATA_WIDTH  lane data; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 validOut  output  LANES  per-lane valid.
REQ-013 busy  output  1  high while a group is partially filled (ptr != 0).

Function
REQ-014 The block SHALL keep an internal lane pointer ptr, an active-lane count act_q and a mode register mode_q.
REQ-015 The block SHALL load lane_cnt into act_q and align_mode into mode_q only on cycles where ptr == 0 and no group is pending.
REQ-016 A lane_cnt of 0 or greater than LANES SHALL load act_q = LANES.
REQ-017 Every registered output SHALL change on a clk_2f rising edge, with a latency of 1 cycle from the input to the output.
REQ-018 Immediate mode, validIn = 1: laneOut[ptr] SHALL be set to dataIn, validOut SHALL equal one-hot(ptr), and ptr SHALL advance to (ptr + 1) mod act_q.
REQ-019 Immediate mode, validIn = 0: validOut SHALL be all zeros, ptr SHALL hold and laneOut SHALL hold.
REQ-020 Aligned mode, validIn = 1: dataIn SHALL be written to buffer slot ptr, ptr SHALL advance modulo act_q, and validOut SHALL stay 0 until the group is complete.
REQ-021 Aligned mode, on the cycle after slot act_q-1 is written: laneOut[0..act_q-1] SHALL present the buffered group, validOut[0..act_q-1] SHALL be 1 for exactly one cycle, and ptr SHALL be 0.
REQ-022 Aligned mode, flush = 1 with ptr != 0: slots ptr..act_q-1 SHALL be filled with PAD_WORD, the group SHALL be emitted on the next cycle, and ptr SHALL be set to 0.
REQ-023 flush and validIn together: the word SHALL be accepted first and the remaining slots padded; if that word completes the group, the emit SHALL be a normal emit with no padding.
REQ-024 flush with ptr == 0, or flush in immediate mode, SHALL have no effect.
REQ-025 Lanes with index >= act_q SHALL drive laneOut = 0 and validOut = 0 at all times.
REQ-026 A group SHALL NOT be emitted while the previous group is still being output; back-to-back full groups SHALL emit on consecutive group completions with no lost words at one word per cycle.
REQ-027 Changes to lane_cnt or align_mode in the middle of a group SHALL be ignored until the group closes, either normally or by flush.

Reset
REQ-028 While reset = 0, asynchronously: ptr = 0, laneOut = 0, validOut = 0, buffer = 0, busy = 0, act_q = LANES and mode_q = 0.
REQ-029 On reset assertion in the middle of a group, the partial group SHALL be discarded with no emit.
REQ-030 After reset deasserts, the first clk_2f edge SHALL sample lane_cnt and align_mode per REQ-015.

Verification
REQ-031 LANES=4, immediate mode, lane_cnt=4, dataIn 0xA0..0xA5 on consecutive cycles -> validOut sequence 0001, 0010, 0100, 1000, 0001, 0010; lane 0 outputs 0xA0 then 0xA4.
REQ-032 Aligned mode, lane_cnt=3, dataIn 0x11, 0x22, 0x33 -> one cycle after 0x33, validOut = 0111 with lanes 0/1/2 = 0x11/0x22/0x33; lane 3 = 0.
REQ-033 Aligned mode, lane_cnt=4, dataIn 0x55, 0x66, then flush with validIn = 0 -> next cycle validOut = 1111 with lanes = 0x55, 0x66, PAD_WORD, PAD_WORD; busy falls to 0.
REQ-034 lane_cnt changed from 4 to 2 after 1 word of a group -> the group completes at 4 lanes; the next group uses 2 lanes (validOut = 0011).
REQ-035 reset pulsed low with ptr = 2 in aligned mode -> outputs 0 immediately without waiting for clk_2f; no emit follows; the next group starts at slot 0.
REQ-036 lane_cnt = 0 or 9 -> act_q = 4, and behaviour is identical to scenario REQ-031.
